// File: rtl/lfsr8_checker.sv
// lfsr8_checker
//   Receive-side checker for the 8-bit right-shift LFSR pattern generator.
//   It hunts for a nonzero seed and verifies LOCK_CNT consecutive predictions.
//   Once locked, it flywheels its own prediction and counts mismatches.
//   After LOSS_CNT back-to-back mismatches it drops lock and hunts again.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   clear      synchronous clear, takes priority over din_valid
//   din_valid  din carries one LFSR state this cycle
//   din        received LFSR state
//   locked     checker is in the LOCKED state
//   err_pulse  one-cycle pulse per mismatch seen while locked
//   err_count  saturating count of mismatches seen while locked
//   expected   predicted value of the next valid din
module lfsr8_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             din_valid,
  input  logic [7:0]       din,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [7:0]       expected
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state, state_d;
  logic [7:0]       expected_d;
  logic [3:0]       match_cnt, match_cnt_d;
  logic [3:0]       miss_cnt, miss_cnt_d;
  logic             locked_d;
  logic             err_pulse_d;
  logic [CNT_W-1:0] err_count_d;

  // Generator step: taps 4,3,2,0 feed the MSB, and the register shifts right.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  // The counters are compared one step ahead, so the transition happens
  // on the sample that reaches the threshold.
  logic match_hit;
  logic loss_hit;
  assign match_hit = (({1'b0, match_cnt} + 5'd1) == 5'(LOCK_CNT));
  assign loss_hit  = (({1'b0, miss_cnt} + 5'd1) == 5'(LOSS_CNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_HUNT;
      expected  <= 8'h00;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_d;
      expected  <= expected_d;
      match_cnt <= match_cnt_d;
      miss_cnt  <= miss_cnt_d;
      locked    <= locked_d;
      err_pulse <= err_pulse_d;
      err_count <= err_count_d;
    end
  end

  // Next-state logic. When din_valid is low, everything holds except err_pulse.
  // When locked, the prediction never reseeds from din, so one corrupted
  // byte costs a single error instead of resynchronising to the bad value.
  always_comb begin
    state_d     = state;
    expected_d  = expected;
    match_cnt_d = match_cnt;
    miss_cnt_d  = miss_cnt;
    err_pulse_d = 1'b0;
    err_count_d = err_count;

    if (clear) begin
      state_d     = ST_HUNT;
      expected_d  = 8'h00;
      match_cnt_d = 4'd0;
      miss_cnt_d  = 4'd0;
      err_count_d = '0;
    end else if (din_valid) begin
      unique case (state)
        ST_HUNT: begin
          if (din != 8'h00) begin
            expected_d  = lfsr_next(din);
            match_cnt_d = 4'd0;
            state_d     = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (din == expected) begin
            match_cnt_d = match_cnt + 4'd1;
            expected_d  = lfsr_next(din);
            if (match_hit) begin
              state_d    = ST_LOCKED;
              miss_cnt_d = 4'd0;
            end
          end else if (din != 8'h00) begin
            expected_d  = lfsr_next(din);
            match_cnt_d = 4'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_LOCKED: begin
          expected_d = lfsr_next(expected);
          if (din == expected) begin
            miss_cnt_d = 4'd0;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count != CNT_MAX) begin
              err_count_d = err_count + CNT_ONE;
            end
            if (loss_hit) begin
              state_d    = ST_HUNT;
              miss_cnt_d = 4'd0;
            end else begin
              miss_cnt_d = miss_cnt + 4'd1;
            end
          end
        end
        default: begin
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  assign locked_d = (state_d == ST_LOCKED);

endmodule
